ps2_keyboard_mmio: RTL

//  Memory-mapped PS/2 keyboard receiver. Feeds the DataIn_KEYBOARD leg of the CPU read-data multiplexer, selected by Keyboard_Select_H.

---
 rtl/ps2_kbd_pkg.sv | 27 ++
 rtl/ps2_rx_frame.sv | 134 +++++++++++++
 rtl/ps2_keyboard_mmio.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared types, register offsets and STATUS bit positions for the PS/2 keyboard block
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_PERR   = 3;
  localparam int ST_FERR   = 4;
  localparam int ST_IE     = 5;
  localparam int ST_COUNT  = 8;

  // True when data plus parity carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver: synchroniser, clock glitch filter, frame FSM, idle timeout
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       perr_o,
  output logic       ferr_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          flt_q, flt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall;
  logic          dat_bit;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          par_ok, stop_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_q      <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      flt_q      <= flt_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
    end
  end

  // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_sync_q[1] != flt_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        flt_d = clk_sync_q[1];
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign fall    = flt_q & ~flt_d;
  assign dat_bit = dat_sync_q[1];
  assign par_ok  = odd_parity_ok(shift_q, par_q);
  assign stop_ok = dat_bit;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_d        = '0;
    byte_valid_o = 1'b0;
    perr_o       = 1'b0;
    ferr_o       = 1'b0;

    if (state_q != RX_IDLE && !fall) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (fall && !dat_bit) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {dat_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = dat_bit;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d      = RX_IDLE;
          perr_o       = ~par_ok;
          ferr_o       = ~stop_ok;
          byte_valid_o = par_ok & stop_ok;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A stalled frame is dropped silently so the next start bit resynchronises.
    if (state_q != RX_IDLE && !fall && tmo_q == TMO_LAST) begin
      state_d = RX_IDLE;
      tmo_d   = '0;
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// rtl/ps2_keyboard_mmio.sv - memory-mapped PS/2 keyboard receiver with scan-code FIFO and DATA/STATUS registers
// Define PS2_KBD_IRQ_EN to enable the IE bit and the registered interrupt output.
module ps2_keyboard_mmio
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        Keyboard_Select_H,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic [3:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic        PS2_CLK_In,
  input  logic        PS2_DAT_In,
  output logic        IRQ_Keyboard_H
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic             rx_valid, rx_perr, rx_ferr;
  logic [7:0]       rx_byte;

  logic             acc, acc_q;
  logic             rd_data_q;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic             empty, full, pop, push_ok, ovf_set, wr_status;
  logic             ie;
  logic [31:0]      status_word;
  logic             unused_din;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (Clock),
    .rst_i       (Reset_H),
    .ps2_clk_i   (PS2_CLK_In),
    .ps2_dat_i   (PS2_DAT_In),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte),
    .perr_o      (rx_perr),
    .ferr_o      (rx_ferr)
  );

  assign acc       = Keyboard_Select_H & ~AS_L;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  // Pop once, on the cycle the access ends, so a multi-cycle read never drains twice.
  assign pop       = acc_q & ~acc & rd_data_q & ~empty;
  assign push_ok   = rx_valid & (~full | pop);
  assign ovf_set   = rx_valid & full & ~pop;
  assign wr_status = acc & ~acc_q & ~WE_L & (Address == REG_STATUS);

  always_comb begin
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d  = (ovf_q  & ~(wr_status & DataIn[ST_OVF]))  | ovf_set;
    perr_d = (perr_q & ~(wr_status & DataIn[ST_PERR])) | rx_perr;
    ferr_d = (ferr_q & ~(wr_status & DataIn[ST_FERR])) | rx_ferr;
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      acc_q     <= 1'b0;
      rd_data_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      acc_q     <= acc;
      rd_data_q <= acc & WE_L & (Address == REG_DATA);
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wptr_q] <= rx_byte;
    end
  end

`ifdef PS2_KBD_IRQ_EN
  logic ie_q, irq_q;

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_status) begin
        ie_q <= DataIn[ST_IE];
      end
      irq_q <= ie_q & ~empty;
    end
  end

  assign ie             = ie_q;
  assign IRQ_Keyboard_H = irq_q;
`else
  assign ie             = 1'b0;
  assign IRQ_Keyboard_H = 1'b0;
`endif

  always_comb begin
    status_word               = '0;
    status_word[ST_NEMPTY]    = ~empty;
    status_word[ST_FULL]      = full;
    status_word[ST_OVF]       = ovf_q;
    status_word[ST_PERR]      = perr_q;
    status_word[ST_FERR]      = ferr_q;
    status_word[ST_IE]        = ie;
    status_word[ST_COUNT +: 8] = 8'(count_q);
  end

  always_comb begin
    DataOut = '0;
    if (acc) begin
      case (Address)
        REG_DATA:   DataOut = {23'b0, ~empty, empty ? 8'h00 : mem_q[rptr_q]};
        REG_STATUS: DataOut = status_word;
        default:    DataOut = '0;
      endcase
    end
  end

  assign unused_din = ^{DataIn[31:6], DataIn[5], DataIn[1:0]};

endmodule
